reg_file: RTL and testbench

- Integer register file of the single-cycle RV32I datapath; sits directly upstream of the ALU.
- rs1_data drives the ALU's first operand (ainn). rs2_data drives the ALU's second operand (bin) through the ALU-source mux.
- Write-back data (ALU result, load data or PC+4, selected outside this block) is committed on the rising clock edge.
- x0 is hardwired to zero.

---
 rtl/rv_pkg.sv | 21 ++
 rtl/reg_file_rd_port.sv | 18 +
 rtl/reg_file.sv | 57 +++++
 tb/tb_reg_file.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RV32I datapath widths and ABI register indices
package rv_pkg;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int AW   = 5;

   typedef logic [XLEN-1:0] xword_t;
   typedef logic [AW-1:0]   reg_idx_t;

   localparam int REG_ZERO = 0;

   localparam reg_idx_t RA = 5'd1;
   localparam reg_idx_t SP = 5'd2;
   localparam reg_idx_t GP = 5'd3;
   localparam reg_idx_t TP = 5'd4;
   localparam reg_idx_t T0 = 5'd5;
   localparam reg_idx_t A0 = 5'd10;
   localparam reg_idx_t A1 = 5'd11;

endpackage

// File: rtl/reg_file_rd_port.sv
// rtl/reg_file_rd_port.sv - combinational register read mux with x0 forced to zero
module reg_file_rd_port
   import rv_pkg::*;
#(
   parameter int XLEN = rv_pkg::XLEN,
   parameter int NREG = rv_pkg::NREG,
   parameter int AW   = rv_pkg::AW
) (
   input  logic [AW-1:0]   addr,
   input  logic [XLEN-1:0] regs [NREG],
   output logic [XLEN-1:0] data
);

   // Masking here as well as on the write side keeps x0 at zero even if the
   // storage slot were ever disturbed.
   assign data = (addr == AW'(REG_ZERO)) ? '0 : regs[addr];

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - RV32I integer register file, one write port, three async read ports
module reg_file
   import rv_pkg::*;
#(
   parameter int XLEN = rv_pkg::XLEN,
   parameter int NREG = rv_pkg::NREG,
   parameter int AW   = rv_pkg::AW
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            reg_write,
   input  logic [AW-1:0]   rd_addr,
   input  logic [XLEN-1:0] rd_data,
   input  logic [AW-1:0]   rs1_addr,
   input  logic [AW-1:0]   rs2_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   input  logic [AW-1:0]   dbg_addr,
   output logic [XLEN-1:0] dbg_data
);

   logic [XLEN-1:0] regs [NREG];

   assign regs[0] = '0;

   // Slot 0 has no flop at all, so writes to x0 simply have nowhere to land.
   for (genvar g = 1; g < NREG; g++) begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            regs[g] <= '0;
         end else if (reg_write && (rd_addr == AW'(g))) begin
            regs[g] <= rd_data;
         end
      end
   end

   // Reads deliberately see only stored state: rd_data comes back through the
   // ALU from these outputs, so forwarding it would close a combinational loop.
   reg_file_rd_port #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) u_rs1 (
      .addr (rs1_addr),
      .regs (regs),
      .data (rs1_data)
   );

   reg_file_rd_port #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) u_rs2 (
      .addr (rs2_addr),
      .regs (regs),
      .data (rs2_data)
   );

   reg_file_rd_port #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) u_dbg (
      .addr (dbg_addr),
      .regs (regs),
      .data (dbg_data)
   );

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - self-checking bench for reg_file against an array model
module tb_reg_file;
   import rv_pkg::*;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            reg_write = 1'b0;
   logic [AW-1:0]   rd_addr = '0;
   logic [XLEN-1:0] rd_data = '0;
   logic [AW-1:0]   rs1_addr = '0;
   logic [AW-1:0]   rs2_addr = '0;
   logic [AW-1:0]   dbg_addr = '0;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic [XLEN-1:0] dbg_data;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   logic [XLEN-1:0] model [NREG];

   reg_file dut (
      .clk       (clk),
      .rst       (rst),
      .reg_write (reg_write),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rs1_addr  (rs1_addr),
      .rs2_addr  (rs2_addr),
      .rs1_data  (rs1_data),
      .rs2_data  (rs2_data),
      .dbg_addr  (dbg_addr),
      .dbg_data  (dbg_data)
   );

   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < NREG; i++) model[i] = '0;
   end

   // Architectural view: registers clear on reset; a write to any nonzero index commits at the edge.
   always @(posedge rst) begin
      for (int i = 0; i < NREG; i++) model[i] = '0;
   end

   always @(posedge clk) begin
      if (!rst && reg_write && rd_addr != 0) model[rd_addr] = rd_data;
   end

   function automatic logic [XLEN-1:0] expect_rd(input logic [AW-1:0] a);
      if (rst || a == 0) return '0;
      return model[a];
   endfunction

   task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("model_rs1", rs1_data, expect_rd(rs1_addr));
         chk("model_rs2", rs2_data, expect_rd(rs2_addr));
         chk("model_dbg", dbg_data, expect_rd(dbg_addr));
      end
   end

   task automatic wr(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
      reg_write = 1'b1;
      rd_addr   = a;
      rd_data   = d;
      @(posedge clk);
      #1;
      reg_write = 1'b0;
   endtask

   logic [XLEN-1:0] alu_y;
   logic [XLEN-1:0] sweep_v;

   initial begin
      @(posedge clk);
      #1;
      cmp_en = 1'b1;
      chk("reset_rs1", rs1_data, 32'h0);
      chk("reset_dbg", dbg_data, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Asynchronous reset mid-cycle, with a write pending across the edge while reset is held.
      wr(T0, 32'hDEADBEEF);
      rs1_addr = T0;
      #1;
      chk("pre_reset_x5", rs1_data, 32'hDEADBEEF);
      rst = 1'b1;
      #1;
      chk("async_reset_x5", rs1_data, 32'h0);
      reg_write = 1'b1;
      rd_addr   = 5'd6;
      rd_data   = 32'h12345678;
      @(posedge clk);
      #1;
      reg_write = 1'b0;
      rst = 1'b0;
      for (int i = 0; i < NREG; i++) begin
         dbg_addr = AW'(i);
         #1;
         chk("reset_sweep", dbg_data, 32'h0);
      end
      @(posedge clk);
      #1;
      wr(5'd6, 32'h0000_00AA);
      dbg_addr = 5'd6;
      #1;
      chk("first_write_after_reset", dbg_data, 32'h0000_00AA);

      // Basic write/read.
      wr(A0, 32'h0000_0007);
      rs1_addr = A0;
      rs2_addr = A0;
      dbg_addr = A1;
      #1;
      chk("basic_rs1", rs1_data, 32'h0000_0007);
      chk("basic_rs2", rs2_data, 32'h0000_0007);
      chk("basic_x11", dbg_data, 32'h0);

      // x0 protection.
      wr(5'd0, 32'hFFFF_FFFF);
      rs1_addr = 5'd0;
      rs2_addr = 5'd0;
      dbg_addr = 5'd0;
      #1;
      chk("x0_rs1", rs1_data, 32'h0);
      chk("x0_rs2", rs2_data, 32'h0);
      chk("x0_dbg", dbg_data, 32'h0);

      // No bypass.
      wr(GP, 32'h0000_0001);
      reg_write = 1'b1;
      rd_addr   = GP;
      rd_data   = 32'h0000_0002;
      rs1_addr  = GP;
      #1;
      chk("nobypass_before", rs1_data, 32'h0000_0001);
      @(posedge clk);
      #1;
      reg_write = 1'b0;
      chk("nobypass_after", rs1_data, 32'h0000_0002);

      // ALU hookup (SUB, ctrl 0110) and write-disable.
      wr(RA, 32'h0000_0009);
      wr(SP, 32'h0000_0004);
      rs1_addr = RA;
      rs2_addr = SP;
      #1;
      alu_y = rs1_data - rs2_data;
      chk("alu_sub", alu_y, 32'h0000_0005);
      reg_write = 1'b0;
      rd_addr   = RA;
      rd_data   = 32'h0;
      @(posedge clk);
      #1;
      chk("write_disable_x1", rs1_data, 32'h0000_0009);

      // Full sweep, read back in reverse order on every port.
      for (int i = 1; i < NREG; i++) wr(AW'(i), (32'(i) << 24) | 32'(i));
      for (int i = NREG - 1; i >= 1; i--) begin
         rs1_addr = AW'(i);
         rs2_addr = AW'(i);
         dbg_addr = AW'(i);
         sweep_v  = (32'(i) << 24) | 32'(i);
         #1;
         chk("sweep_rs1", rs1_data, sweep_v);
         chk("sweep_rs2", rs2_data, sweep_v);
         chk("sweep_dbg", dbg_data, sweep_v);
      end
      dbg_addr = 5'd0;
      #1;
      chk("sweep_x0", dbg_data, 32'h0);

      // Randomized traffic with occasional asynchronous reset pulses.
      for (int n = 0; n < 400; n++) begin
         reg_write = ($urandom_range(0, 3) != 0);
         rd_addr   = AW'($urandom_range(0, NREG - 1));
         rd_data   = $urandom;
         rs1_addr  = AW'($urandom_range(0, NREG - 1));
         rs2_addr  = ($urandom_range(0, 3) == 0) ? rs1_addr : AW'($urandom_range(0, NREG - 1));
         dbg_addr  = ($urandom_range(0, 3) == 0) ? rd_addr : AW'($urandom_range(0, NREG - 1));
         if ($urandom_range(0, 60) == 0) rst = 1'b1;
         @(posedge clk);
         #1;
         rst = 1'b0;
      end
      reg_write = 1'b0;
      @(posedge clk);
      #1;
      cmp_en = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
